// File: rtl/register_chain_pkg.sv
// Shared types and constants for the register chain driver.
package register_chain_pkg;

   localparam int unsigned CHAIN_LEN_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UPDATE,
      DONE
   } state_t;

endpackage

// File: rtl/register_chain_driver_if.sv
// Host handshake and chain-side signals of the register chain driver.
interface register_chain_driver_if #(
   parameter int unsigned CHAIN_LEN = register_chain_pkg::CHAIN_LEN_DEFAULT
);

   logic [CHAIN_LEN-1:0] data_in;
   logic                 data_valid;
   logic                 data_ready;
   logic                 chain_data;
   logic                 chain_enable;
   logic                 chain_update;
   logic                 chain_return;
   logic                 busy;
   logic                 done;
   logic [CHAIN_LEN-1:0] readback_data;
   logic                 readback_valid;

   modport master (
      output data_in, data_valid, chain_return,
      input  data_ready, chain_data, chain_enable, chain_update,
             busy, done, readback_data, readback_valid
   );

   modport slave (
      input  data_in, data_valid, chain_return,
      output data_ready, chain_data, chain_enable, chain_update,
             busy, done, readback_data, readback_valid
   );

endinterface

// File: rtl/register_chain_serializer.sv
// Parallel-load MSB-first shift register with registered serial bit and shift down-counter.
module register_chain_serializer
   import register_chain_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 shift_i,
   input  logic                 clear_i,
   input  logic [CHAIN_LEN-1:0] data_i,
   output logic                 bit_o,
   output logic                 last_o
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 bit_q, bit_d;

   // The MSB leaves on load straight into bit_q, so sr holds only the bits still to send.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      bit_d = bit_q;
      if (load_i) begin
         bit_d = data_i[CHAIN_LEN-1];
         sr_d  = data_i << 1;
         cnt_d = CNT_W'(CHAIN_LEN);
      end else if (clear_i) begin
         bit_d = 1'b0;
         sr_d  = '0;
         cnt_d = '0;
      end else if (shift_i) begin
         bit_d = sr_q[CHAIN_LEN-1];
         sr_d  = sr_q << 1;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
         bit_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
      end
   end

   assign bit_o  = bit_q;
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/register_chain_driver.sv
// Serial register chain driver: shift, update pulse, done pulse.
// Optional readback of previous chain contents with macro REGISTER_CHAIN_READBACK_EN.
module register_chain_driver
   import register_chain_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   register_chain_driver_if.slave  bus_io
);

   state_t state_q, state_d;
   logic   enable_q, enable_d;
   logic   update_q, update_d;
   logic   done_q, done_d;
   logic   load, shift, clear;
   logic   ser_bit, ser_last;

   register_chain_serializer #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_serializer (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .shift_i (shift),
      .clear_i (clear),
      .data_i  (bus_io.data_in),
      .bit_o   (ser_bit),
      .last_o  (ser_last)
   );

   always_comb begin
      state_d  = state_q;
      enable_d = 1'b0;
      update_d = 1'b0;
      done_d   = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;
      clear    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_io.data_valid) begin
               state_d  = SHIFT;
               enable_d = 1'b1;
               load     = 1'b1;
            end
         end
         SHIFT: begin
            if (ser_last) begin
               state_d  = UPDATE;
               update_d = 1'b1;
               clear    = 1'b1;
            end else begin
               enable_d = 1'b1;
               shift    = 1'b1;
            end
         end
         UPDATE: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         enable_q <= 1'b0;
         update_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         update_q <= update_d;
         done_q   <= done_d;
      end
   end

   assign bus_io.data_ready   = (state_q == IDLE);
   assign bus_io.busy         = (state_q != IDLE);
   assign bus_io.chain_data   = ser_bit;
   assign bus_io.chain_enable = enable_q;
   assign bus_io.chain_update = update_q;
   assign bus_io.done         = done_q;

`ifdef REGISTER_CHAIN_READBACK_EN
   logic [CHAIN_LEN-1:0] rb_q;
   logic                 rbv_q;

   // Sampled on the same edge the cells shift, so the last cell's pre-shift value is captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rb_q  <= '0;
         rbv_q <= 1'b0;
      end else begin
         if (enable_q) begin
            rb_q <= (rb_q << 1) | CHAIN_LEN'(bus_io.chain_return);
         end
         rbv_q <= done_d;
      end
   end

   assign bus_io.readback_data  = rb_q;
   assign bus_io.readback_valid = rbv_q;
`else
   logic unused_chain_return;

   assign unused_chain_return   = bus_io.chain_return;
   assign bus_io.readback_data  = '0;
   assign bus_io.readback_valid = 1'b0;
`endif

endmodule

// File: tb/tb_register_chain_driver.sv
// Bench for register_chain_driver: CHAIN_LEN=8 and CHAIN_LEN=1 instances driving modelled chains.
module tb_register_chain_driver;

   localparam int N = 8;
`ifdef REGISTER_CHAIN_READBACK_EN
   localparam int RB_EN = 1;
`else
   localparam int RB_EN = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   register_chain_driver_if #(.CHAIN_LEN(N)) bus8 ();
   register_chain_driver_if #(.CHAIN_LEN(1)) bus1 ();

   register_chain_driver #(.CHAIN_LEN(N)) dut8 (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus8)
   );

   register_chain_driver #(.CHAIN_LEN(1)) dut1 (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus1)
   );

   // Chain cell models: cell 0 nearest the driver, cells are not reset.
   logic [N-1:0] cells8 = '0;
   logic         cells1 = 1'b0;

   always @(posedge clk) if (bus8.chain_enable) cells8 <= {cells8[N-2:0], bus8.chain_data};
   always @(posedge clk) if (bus1.chain_enable) cells1 <= bus1.chain_data;

   assign bus8.chain_return = cells8[N-1];
   assign bus1.chain_return = cells1;

   int checks = 0;
   int errors = 0;
   logic sb_q[$];

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_rb;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [7:0] word);
      int waited = 0;
      while (bus8.data_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", int'(bus8.data_ready), 1);
      bus8.data_in    = word;
      bus8.data_valid = 1'b1;
      for (int i = N - 1; i >= 0; i--) sb_q.push_back(word[i]);
      @(posedge clk);
   endtask

   // Called right after the accept edge; observes cycles 1..N+3.
   task automatic observe(input logic [7:0] word, input bit keep_valid, input logic [7:0] next_data,
                          input int pulse_cycle, input bit check_rb, input logic [7:0] exp_rb);
      int en_first = 0;
      int en_cnt = 0;
      int upd_cyc = 0;
      int done_cyc = 0;
      int rbv_cyc = 0;
      int bad_busy = 0;
      int bad_data = 0;
      logic [7:0] rb_done = '0;
      for (int c = 1; c <= N + 3; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus8.data_valid = keep_valid;
            bus8.data_in    = next_data;
            if (keep_valid) for (int i = N - 1; i >= 0; i--) sb_q.push_back(next_data[i]);
         end
         if (pulse_cycle != 0) bus8.data_valid = (c == pulse_cycle);
         if (bus8.chain_enable === 1'b1) begin
            if (en_first == 0) en_first = c;
            en_cnt++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL chain_data: extra shift bit for word 0x%0h, none expected", word);
            end else begin
               check("chain_data", int'(bus8.chain_data), int'(sb_q.pop_front()));
            end
         end else if (bus8.chain_data !== 1'b0) begin
            bad_data++;
         end
         if (bus8.chain_update === 1'b1) begin
            upd_cyc = (upd_cyc == 0) ? c : -1;
            if (bus8.chain_enable === 1'b1) bad_data++;
         end
         if (bus8.done === 1'b1) begin
            done_cyc = (done_cyc == 0) ? c : -1;
            rb_done  = bus8.readback_data;
         end
         if (bus8.readback_valid === 1'b1) rbv_cyc = (rbv_cyc == 0) ? c : -1;
         if (c <= N + 2 && (bus8.busy !== 1'b1 || bus8.data_ready !== 1'b0)) bad_busy++;
      end
      check("ready_after", int'({bus8.data_ready, bus8.busy}), 2);
      check("en_first", en_first, 1);
      check("en_count", en_cnt, N);
      check("update_cycle", upd_cyc, N + 1);
      check("done_cycle", done_cyc, N + 2);
      check("busy_ready", bad_busy, 0);
      check("data_idle_overlap", bad_data, 0);
      check("rbv_cycle", rbv_cyc, (RB_EN != 0) ? N + 2 : 0);
      if (check_rb || RB_EN == 0) check("readback", int'(rb_done), (RB_EN != 0) ? int'(exp_rb) : 0);
   endtask

   initial begin
      int stray;
      int en_first, en_cnt, upd_cyc, done_cyc, rbv_cyc;
      logic b, prev1, rb1;

      vecs[0] = '{data: 8'h3C, exp_rb: 8'h00};
      vecs[1] = '{data: 8'hA5, exp_rb: 8'h3C};
      vecs[2] = '{data: 8'h00, exp_rb: 8'hA5};
      vecs[3] = '{data: 8'hFF, exp_rb: 8'h00};
      vecs[4] = '{data: 8'h5A, exp_rb: 8'hFF};

      bus8.data_in    = '0;
      bus8.data_valid = 1'b0;
      bus1.data_in    = '0;
      bus1.data_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ctrl8", int'({bus8.data_ready, bus8.busy, bus8.chain_enable, bus8.chain_data,
                                bus8.chain_update, bus8.done, bus8.readback_valid}), 'h40);
      check("rst_rb8", int'(bus8.readback_data), 0);
      check("rst_ctrl1", int'({bus1.data_ready, bus1.busy, bus1.chain_enable, bus1.chain_data,
                                bus1.chain_update, bus1.done, bus1.readback_valid}), 'h40);

      // Accept on the first edge after reset release.
      reset = 1'b0;
      for (int v = 0; v < 5; v++) begin
         drive(vecs[v].data);
         observe(vecs[v].data, 1'b0, vecs[v].data, 0, 1'b1, vecs[v].exp_rb);
      end

      // Abort in shift cycle 4.
      drive(8'hC3);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) bus8.data_valid = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("abort_ctrl", int'({bus8.data_ready, bus8.busy, bus8.chain_enable, bus8.chain_data,
                                 bus8.chain_update, bus8.done, bus8.readback_valid}), 'h40);
      check("abort_rb", int'(bus8.readback_data), 0);
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0;
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus8.chain_enable || bus8.chain_update || bus8.done) stray++;
      end
      check("abort_quiet", stray, 0);
      drive(8'hFF);
      observe(8'hFF, 1'b0, 8'hFF, 0, 1'b0, 8'h00);
      drive(8'h96);
      observe(8'h96, 1'b0, 8'h96, 0, 1'b1, 8'hFF);

      // Held data_valid: second accept at the end of cycle N+3.
      drive(8'h11);
      observe(8'h11, 1'b1, 8'h22, 0, 1'b0, 8'h00);
      check("held_valid", int'(bus8.data_valid), 1);
      @(posedge clk);
      observe(8'h22, 1'b0, 8'h22, 0, 1'b1, 8'h11);

      // Valid pulse while busy is dropped.
      drive(8'h33);
      observe(8'h33, 1'b0, 8'h33, 5, 1'b1, 8'h22);
      stray = 0;
      repeat (2 * N) begin
         @(negedge clk);
         if (bus8.chain_enable || bus8.busy) stray++;
      end
      check("no_extra_shift", stray, 0);
      check("sb_empty", sb_q.size(), 0);

      // CHAIN_LEN = 1 instance.
      prev1 = 1'b0;
      for (int w = 0; w < 2; w++) begin
         b = (w == 0);
         en_first = 0; en_cnt = 0; upd_cyc = 0; done_cyc = 0; rbv_cyc = 0; rb1 = 1'b0;
         bus1.data_in    = 1'(b);
         bus1.data_valid = 1'b1;
         @(posedge clk);
         for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus1.data_valid = 1'b0;
            if (bus1.chain_enable === 1'b1) begin
               if (en_first == 0) en_first = c;
               en_cnt++;
               check("n1_data", int'(bus1.chain_data), int'(b));
            end
            if (bus1.chain_update === 1'b1) upd_cyc = (upd_cyc == 0) ? c : -1;
            if (bus1.done === 1'b1) begin
               done_cyc = (done_cyc == 0) ? c : -1;
               rb1 = bus1.readback_data[0];
            end
            if (bus1.readback_valid === 1'b1) rbv_cyc = (rbv_cyc == 0) ? c : -1;
         end
         check("n1_en_first", en_first, 1);
         check("n1_en_count", en_cnt, 1);
         check("n1_update", upd_cyc, 2);
         check("n1_done", done_cyc, 3);
         check("n1_rbv", rbv_cyc, (RB_EN != 0) ? 3 : 0);
         check("n1_readback", int'(rb1), (RB_EN != 0) ? int'(prev1) : 0);
         check("n1_ready", int'(bus1.data_ready), 1);
         prev1 = b;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/register_chain_driver.md
REGISTER_CHAIN_DRIVER -- requirements
Module: register_chain_driver

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of register cells in the chain; legal range 1..256.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  CHAIN_LEN  parallel word to load into the chain.
REQ-005 data_valid  input  1  data_in is valid.
REQ-006 data_ready  output  1  driver can accept a word.
REQ-007 chain_data  output  1  serial bit to the first cell's chain_in.
REQ-008 chain_enable  output  1  shift enable to all cells.
REQ-009 chain_update  output  1  one-cycle pulse to all cells' update input.
REQ-010 chain_return  input  1  serial bit from the last cell's chain_out.
REQ-011 busy  output  1  high from the accept cycle until done clears.
REQ-012 done  output  1  one-cycle pulse after the update completes.
REQ-013 readback_data  output  CHAIN_LEN  previous chain contents, captured during the last shift.
REQ-014 readback_valid  output  1  one-cycle pulse coincident with done when readback_data is fresh.

Function
REQ-015 Handshake: a transfer occurs on the rising edge where data_valid && data_ready; data_in is captured at that edge.
REQ-016 data_ready is high only in IDLE; data_valid outside IDLE is ignored, with no queuing.
REQ-017 FSM states: IDLE -> SHIFT on accept, SHIFT -> UPDATE after CHAIN_LEN shift cycles, UPDATE -> DONE after 1 cycle, DONE -> IDLE after 1 cycle.
REQ-018 All chain-side outputs are registered. With accept at edge E0, cycles 1..CHAIN_LEN have chain_enable=1, cycle CHAIN_LEN+1 has chain_update=1, and cycle CHAIN_LEN+2 has done=1.
REQ-019 Shift order is MSB first: shift cycle k (1-based) drives data_in[CHAIN_LEN-k], so cell i (0 = nearest the driver) holds data_in[i] after the shift.
REQ-020 chain_enable is exactly CHAIN_LEN consecutive cycles and is never high in UPDATE, DONE or IDLE.
REQ-021 chain_data is 0 whenever chain_enable is 0.
REQ-022 chain_update is never high in the same cycle as chain_enable.
REQ-023 The shift counter is $clog2(CHAIN_LEN+1) bits wide, counts down from CHAIN_LEN, and SHIFT exits at 1; CHAIN_LEN=1 gives a single shift cycle.
REQ-024 busy = (state != IDLE).
REQ-025 A held data_valid is next accepted in cycle CHAIN_LEN+3 (back in IDLE).

Reset
REQ-026 Reset state: FSM in IDLE; data_ready=1; all other outputs, the counter and the shift registers are 0.
REQ-027 Reset mid-operation aborts immediately.
REQ-028 After an abort, no chain_update pulse and no done pulse are issued for the aborted word; chain cell contents are undefined.
REQ-029 The first accept after reset deassertion is possible at the first rising edge after deassertion.

Configuration
REQ-030 Macro REGISTER_CHAIN_READBACK_EN defined: during each shift cycle, chain_return is sampled on the same rising edge the cells capture and shifted LSB-in into the readback register.
REQ-031 With the macro defined, readback_data[i] equals the pre-load content of cell i after CHAIN_LEN samples, and readback_valid pulses with done.
REQ-032 Macro REGISTER_CHAIN_READBACK_EN undefined: readback logic is absent, readback_data=0, readback_valid=0, and chain_return is unused.

Structure
REQ-033 Shared package register_chain_pkg holds the FSM state enum (IDLE, SHIFT, UPDATE, DONE) and the CHAIN_LEN default constant.
REQ-034 One sub-module, register_chain_serializer, contains the parallel-load MSB-first shift register and the down-counter; the FSM stays in the top module.

Verification (CHAIN_LEN=8)
REQ-035 Load 0xA5 -> chain_data over shift cycles 1..8 is 1,0,1,0,0,1,0,1; chain_enable is high for exactly 8 cycles; chain_update is high in cycle 9; done is high in cycle 10.
REQ-036 Macro on, chain preloaded with 0x3C, then load 0xA5 -> readback_data=0x3C with readback_valid in cycle 10; a following load of 0x00 -> readback_data=0xA5.
REQ-037 Reset asserted in shift cycle 4 -> all outputs 0 and data_ready=1 while in reset; no chain_update or done pulse occurs; the next load of 0xFF completes normally.
REQ-038 data_valid held continuously with 0x11 then 0x22 -> second accept in cycle 11; data_valid pulsed during busy -> ignored, with no extra shift.
REQ-039 CHAIN_LEN=1, load 1 -> chain_enable for 1 cycle with chain_data=1, update in cycle 2, done in cycle 3.
REQ-040 Macro off -> readback_data=0 and readback_valid=0 throughout the REQ-036 stimulus.
